// File: rtl/mem_tg2_cfg_width_adapter.sv
// 64-bit AVMM CSR slave to 32-bit TG2 config master width adapter.
// Splits each access into low/high halves and bounds read waits with a timeout.
module mem_tg2_cfg_width_adapter #(
   parameter int S_ADDR_W    = 9,
   parameter int M_ADDR_W    = 10,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_read,
   input  logic                s_write,
   input  logic [S_ADDR_W-1:0] s_address,
   input  logic [63:0]         s_writedata,
   input  logic [7:0]          s_byteenable,
   output logic                s_waitrequest,
   output logic [63:0]         s_readdata,
   output logic                s_readdatavalid,
   output logic                m_read,
   output logic                m_write,
   output logic [M_ADDR_W-1:0] m_address,
   output logic [31:0]         m_writedata,
   output logic [3:0]          m_byteenable,
   input  logic                m_waitrequest,
   input  logic [31:0]         m_readdata,
   input  logic                m_readdatavalid,
   output logic                err_timeout,
   output logic                err_stray
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [31:0] TO_WORD = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE, WR_LO, WR_HI, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RESP
   } state_t;

   state_t              state_q, state_d;
   logic [S_ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic [7:0]          be_q, be_d;
   logic [31:0]         lo_q, lo_d;
   logic [31:0]         hi_q, hi_d;
   logic [63:0]         rdata_q, rdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                err_to_q, err_to_d;
   logic                err_st_q, err_st_d;
   logic                is_wait;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         err_to_q <= 1'b0;
         err_st_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         err_to_q <= err_to_d;
         err_st_q <= err_st_d;
      end
   end

   // Next-state, half capture, timeout count and error flags
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      rdata_d  = rdata_q;
      cnt_d    = '0;
      err_to_d = err_to_q;
      err_st_d = err_st_q;
      is_wait  = (state_q == WAIT_LO) || (state_q == WAIT_HI);
      if (m_readdatavalid && !is_wait) err_st_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (s_write || s_read) begin
               addr_d  = s_address;
               wdata_d = s_writedata;
               be_d    = s_byteenable;
               lo_d    = '0;
               hi_d    = '0;
            end
            // Write wins when both are requested
            if (s_write) begin
               if (|s_byteenable[3:0])      state_d = WR_LO;
               else if (|s_byteenable[7:4]) state_d = WR_HI;
               else                         state_d = IDLE;
            end else if (s_read) begin
               if (|s_byteenable[3:0])      state_d = RD_LO;
               else if (|s_byteenable[7:4]) state_d = RD_HI;
               else                         state_d = RESP;
            end
         end
         WR_LO: begin
            if (!m_waitrequest) state_d = (|be_q[7:4]) ? WR_HI : IDLE;
         end
         WR_HI: begin
            if (!m_waitrequest) state_d = IDLE;
         end
         RD_LO: begin
            if (!m_waitrequest) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (m_readdatavalid) begin
               lo_d    = m_readdata;
               state_d = (|be_q[7:4]) ? RD_HI : RESP;
            end else if (cnt_q == TLAST) begin
               lo_d     = TO_WORD;
               err_to_d = 1'b1;
               state_d  = (|be_q[7:4]) ? RD_HI : RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_HI: begin
            if (!m_waitrequest) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (m_readdatavalid) begin
               hi_d    = m_readdata;
               state_d = RESP;
            end else if (cnt_q == TLAST) begin
               hi_d     = TO_WORD;
               err_to_d = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Response word is latched on entry so it holds until the next one
      if (state_d == RESP) rdata_d = {hi_d, lo_d};
   end

   // Master command and slave status outputs decoded from state
   always_comb begin
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
      m_byteenable = '0;
      unique case (state_q)
         WR_LO: begin
            m_write      = 1'b1;
            m_address    = {addr_q, 1'b0};
            m_writedata  = wdata_q[31:0];
            m_byteenable = be_q[3:0];
         end
         WR_HI: begin
            m_write      = 1'b1;
            m_address    = {addr_q, 1'b1};
            m_writedata  = wdata_q[63:32];
            m_byteenable = be_q[7:4];
         end
         RD_LO: begin
            m_read       = 1'b1;
            m_address    = {addr_q, 1'b0};
            m_byteenable = be_q[3:0];
         end
         RD_HI: begin
            m_read       = 1'b1;
            m_address    = {addr_q, 1'b1};
            m_byteenable = be_q[7:4];
         end
         default: ;
      endcase
      s_waitrequest   = (state_q != IDLE) | reset;
      s_readdatavalid = (state_q == RESP);
      s_readdata      = rdata_q;
      err_timeout     = err_to_q;
      err_stray       = err_st_q;
   end

endmodule
